// File: rtl/acq_display_ctrl.sv
// rtl/acq_display_ctrl.sv - scope acquisition/display sequencer
// Arms a trigger on the ADC stream, captures N_SMP samples, then drives the interpolator through N_PIX pixels.
module acq_display_ctrl #(
  parameter int N_SMP    = 256,
  parameter int N_PIX    = 768,
  parameter int AUTO_TMO = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        single,
  input  logic        auto_en,
  input  logic [11:0] trig_level,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  input  logic        vblank,
  output logic        smp_we,
  output logic [7:0]  smp_waddr,
  output logic [11:0] smp_wdata,
  output logic        itp_valid,
  input  logic        itp_ready,
  output logic [7:0]  itp_raddr_a,
  output logic [7:0]  itp_raddr_b,
  output logic [1:0]  itp_phase,
  output logic [9:0]  itp_waddr,
  output logic        frame_done,
  output logic        busy,
  output logic [2:0]  state_o
);

  localparam int TW = (AUTO_TMO > 2) ? $clog2(AUTO_TMO) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_VBL = 3'd3,
    S_INTERP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [11:0]   prev_data;
  logic          prev_valid;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    waddr;
  logic          vbl_q;
  logic          itp_valid_q;
  logic [7:0]    itp_i;
  logic [1:0]    itp_ph;
  logic [9:0]    itp_p;
  logic          frame_done_q;

  logic trig_hit, wr_en, vbl_rise, hs, last_pix, cap_last;

  always_comb begin
    trig_hit = adc_valid &&
               ((prev_valid && (prev_data < trig_level) && (adc_data >= trig_level)) ||
                (auto_en && (tmo_cnt == TW'(AUTO_TMO - 1))));
    wr_en    = ((state == S_ARM) && trig_hit) || ((state == S_CAPTURE) && adc_valid);
    cap_last = (state == S_CAPTURE) && adc_valid && (waddr == 8'(N_SMP - 1));
    vbl_rise = vblank && !vbl_q;
    hs       = itp_valid_q && itp_ready;
    last_pix = hs && (itp_p == 10'(N_PIX - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (run || single) state_nxt = S_ARM;
      S_ARM:      if (trig_hit)      state_nxt = S_CAPTURE;
      S_CAPTURE:  if (cap_last)      state_nxt = S_WAIT_VBL;
      S_WAIT_VBL: if (vbl_rise)      state_nxt = S_INTERP;
      S_INTERP:   if (last_pix)      state_nxt = run ? S_ARM : S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Write strobe is combinational off adc_valid; rst masks it so nothing lands during reset.
  always_comb begin
    smp_we      = wr_en && !rst;
    smp_waddr   = smp_we ? waddr : 8'd0;
    smp_wdata   = smp_we ? adc_data : 12'd0;
    itp_valid   = itp_valid_q;
    itp_raddr_a = itp_i;
    itp_raddr_b = !itp_valid_q ? 8'd0 :
                  (itp_i == 8'(N_SMP - 1)) ? itp_i : itp_i + 8'd1;
    itp_phase   = itp_ph;
    itp_waddr   = itp_p;
    frame_done  = frame_done_q;
    busy        = (state != S_IDLE);
    state_o     = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data    <= 12'd0;
      prev_valid   <= 1'b0;
      tmo_cnt      <= '0;
      waddr        <= 8'd0;
      vbl_q        <= 1'b0;
      itp_valid_q  <= 1'b0;
      itp_i        <= 8'd0;
      itp_ph       <= 2'd0;
      itp_p        <= 10'd0;
      frame_done_q <= 1'b0;
    end else begin
      vbl_q        <= vblank;
      frame_done_q <= last_pix;

      // Trigger history lives only inside ARM; any other state invalidates it.
      if (state == S_ARM) begin
        if (adc_valid) begin
          prev_data  <= adc_data;
          prev_valid <= 1'b1;
          if (tmo_cnt != TW'(AUTO_TMO - 1)) tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        prev_valid <= 1'b0;
        tmo_cnt    <= '0;
      end

      if (wr_en) waddr <= cap_last ? 8'd0 : waddr + 8'd1;

      if ((state == S_WAIT_VBL) && vbl_rise) begin
        itp_valid_q <= 1'b1;
        itp_i       <= 8'd0;
        itp_ph      <= 2'd0;
        itp_p       <= 10'd0;
      end else if (hs) begin
        if (last_pix) begin
          itp_valid_q <= 1'b0;
          itp_i       <= 8'd0;
          itp_ph      <= 2'd0;
          itp_p       <= 10'd0;
        end else begin
          itp_p <= itp_p + 10'd1;
          if (itp_ph == 2'd2) begin
            itp_ph <= 2'd0;
            itp_i  <= itp_i + 8'd1;
          end else begin
            itp_ph <= itp_ph + 2'd1;
          end
        end
      end
    end
  end

endmodule
